// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-word pipeline register: bus layout,
// widths and a small popcount helper used for occupancy tracking.
package ctrl_pipe_pkg;

  localparam int CTRL_W    = 9;
  localparam int MAX_DEPTH = 4;

  typedef struct packed {
    logic       reg_wr;
    logic       wr_en;
    logic       rd_en;
    logic       cs;
    logic       csr_reg_wr;
    logic       csr_reg_rd;
    logic       is_mret;
    logic [1:0] wb_sel;
  } ctrl_bus_t;

  function automatic logic [2:0] countOnes(input logic [MAX_DEPTH-1:0] bits);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + {2'b00, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ctrl_pipe_slot.sv
// One pipeline stage: a valid bit plus payload. The payload is zeroed
// whenever the stage empties so stale control bits never leak downstream.
module ctrl_pipe_slot
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = CTRL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             valid_d_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Clear beats load, load beats drain: a stage that hands its entry on and
  // receives a new one in the same cycle simply takes the new entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign data_o    = data_q;

endmodule

// File: rtl/ctrl_pipe_reg.sv
// Elastic control-word pipeline of DEPTH stages with full-throughput
// back-to-front ready, whole-pipe flush and young-stage flush.
module ctrl_pipe_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = CTRL_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush_all,
  input  logic                       flush_young,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     valid_q, valid_d, advance, load, clear;
  logic [WIDTH-1:0]     data_q [DEPTH];
  logic [WIDTH-1:0]     slotIn [DEPTH];
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [MAX_DEPTH-1:0] validPad;
  logic                 outFire, accept;

  assign outFire = valid_q[DEPTH-1] & out_ready & ~reset;

  // Closed form of the ready chain: a stage moves if anything downstream is
  // empty, or everything downstream is full and the tail is being consumed.
  always_comb begin : advance_chain
    logic fullBelow;
    fullBelow = 1'b1;
    advance   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      advance[k] = valid_q[k] & (~fullBelow | outFire);
      fullBelow  = fullBelow & valid_q[k];
    end
  end

  // Any flush discards the concurrent input, so it is never signalled as accepted.
  assign in_ready = (~valid_q[0] | advance[0]) & ~flush_all & ~flush_young & ~reset;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam bit IS_LAST = (k == DEPTH - 1);

    if (k == 0) begin : g_head
      assign load[k]   = accept;
      assign slotIn[k] = in_data;
    end else begin : g_body
      assign load[k]   = advance[k-1] & ~(flush_young & IS_LAST);
      assign slotIn[k] = data_q[k-1];
    end

    assign clear[k] = flush_all | (flush_young & ~IS_LAST);

    ctrl_pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load[k]),
      .drain_i  (advance[k]),
      .clear_i  (clear[k]),
      .data_i   (slotIn[k]),
      .valid_o  (valid_q[k]),
      .valid_d_o(valid_d[k]),
      .data_o   (data_q[k])
    );
  end

  always_comb begin
    validPad             = '0;
    validPad[DEPTH-1:0]  = valid_d;
    occ_d                = OCC_W'(countOnes(validPad));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Suppress the tail during reset so an in-flight entry cannot complete a handshake.
  assign out_valid = valid_q[DEPTH-1] & ~reset;
  assign out_data  = out_valid ? data_q[DEPTH-1] : '0;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Scoreboard bench for ctrl_pipe_reg: a DEPTH=2 instance checked through an
// expected-output queue, plus a DEPTH=3 instance for the young-flush case.
module tb_ctrl_pipe_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       inValid, outReady, flushAll, flushYoung;
  logic [8:0] inData;
  logic       inReady, outValid;
  logic [8:0] outData;
  logic [1:0] occupancy;

  logic       d3InValid, d3OutReady, d3FlushAll, d3FlushYoung;
  logic [8:0] d3InData;
  logic       d3InReady, d3OutValid;
  logic [8:0] d3OutData;
  logic [1:0] d3Occupancy;

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] sbQ[$];

  always #5 clk = ~clk;

  ctrl_pipe_reg #(.WIDTH(9), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_data    (inData),
    .in_ready   (inReady),
    .out_valid  (outValid),
    .out_data   (outData),
    .out_ready  (outReady),
    .flush_all  (flushAll),
    .flush_young(flushYoung),
    .occupancy  (occupancy)
  );

  ctrl_pipe_reg #(.WIDTH(9), .DEPTH(3)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (d3InValid),
    .in_data    (d3InData),
    .in_ready   (d3InReady),
    .out_valid  (d3OutValid),
    .out_data   (d3OutData),
    .out_ready  (d3OutReady),
    .flush_all  (d3FlushAll),
    .flush_young(d3FlushYoung),
    .occupancy  (d3Occupancy)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (outValid && outReady) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard: unexpected output 0x%0h, expected none", outData);
      end else begin
        checkOutput("scoreboard order", outData, sbQ.pop_front());
      end
    end
  end

  // One cycle of DEPTH=2 stimulus; keep >= 0 trims flushed entries from the queue tail.
  task automatic applyStimulus(input string tag, input logic iv, input logic [8:0] d,
                               input logic ordy, input logic fa, input logic fy, input logic rst,
                               input logic expOv, input logic [8:0] expOd, input logic expIr,
                               input logic [1:0] expOcc, input int keep);
    inValid    = iv;
    inData     = d;
    outReady   = ordy;
    flushAll   = fa;
    flushYoung = fy;
    reset      = rst;
    if (iv && expIr) sbQ.push_back(d);
    @(negedge clk);
    #1;
    checkOutput({tag, " out_valid"}, outValid, expOv);
    checkOutput({tag, " out_data"}, outData, expOd);
    checkOutput({tag, " in_ready"}, inReady, expIr);
    checkOutput({tag, " occupancy"}, occupancy, expOcc);
    if (keep >= 0) begin
      while (sbQ.size() > keep) void'(sbQ.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus3(input string tag, input logic iv, input logic [8:0] d,
                                input logic ordy, input logic fy,
                                input logic expOv, input logic [8:0] expOd, input logic expIr,
                                input logic [1:0] expOcc);
    d3InValid    = iv;
    d3InData     = d;
    d3OutReady   = ordy;
    d3FlushYoung = fy;
    @(negedge clk);
    #1;
    checkOutput({tag, " d3 out_valid"}, d3OutValid, expOv);
    checkOutput({tag, " d3 out_data"}, d3OutData, expOd);
    checkOutput({tag, " d3 in_ready"}, d3InReady, expIr);
    checkOutput({tag, " d3 occupancy"}, d3Occupancy, expOcc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {inValid, outReady, flushAll, flushYoung} = '0;
    inData = '0;
    {d3InValid, d3OutReady, d3FlushAll, d3FlushYoung} = '0;
    d3InData = '0;
    repeat (2) @(posedge clk);
    #1;

    //            tag    iv  data    or fa fy rst ov  odata   ir occ keep
    applyStimulus("RST0", 0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // Back-to-back stream, latency DEPTH
    applyStimulus("S0",   1, 9'h001, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("S1",   1, 9'h002, 1, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("S2",   1, 9'h003, 1, 0, 0, 0,  1, 9'h001, 1, 2, -1);
    applyStimulus("S3",   0, 9'h000, 1, 0, 0, 0,  1, 9'h002, 1, 2, -1);
    applyStimulus("S4",   0, 9'h000, 1, 0, 0, 0,  1, 9'h003, 1, 1, -1);
    applyStimulus("S5",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // Backpressure: full pipe stalls for three cycles then drains in order
    applyStimulus("B0",   1, 9'h011, 0, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("B1",   1, 9'h022, 0, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("B2",   1, 9'h033, 0, 0, 0, 0,  1, 9'h011, 0, 2, -1);
    applyStimulus("B3",   1, 9'h033, 0, 0, 0, 0,  1, 9'h011, 0, 2, -1);
    applyStimulus("B4",   1, 9'h033, 0, 0, 0, 0,  1, 9'h011, 0, 2, -1);
    applyStimulus("B5",   0, 9'h000, 1, 0, 0, 0,  1, 9'h011, 1, 2, -1);
    applyStimulus("B6",   0, 9'h000, 1, 0, 0, 0,  1, 9'h022, 1, 1, -1);
    applyStimulus("B7",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // flush_all on a full pipe with concurrent input
    applyStimulus("F0",   1, 9'h044, 0, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("F1",   1, 9'h055, 0, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("F2",   1, 9'h066, 0, 1, 0, 0,  1, 9'h044, 0, 2,  0);
    applyStimulus("F3",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("F4",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // flush_young keeps the tail entry
    applyStimulus("Y0",   1, 9'h077, 0, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("Y1",   1, 9'h088, 0, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("Y2",   1, 9'h099, 0, 0, 1, 0,  1, 9'h077, 0, 2,  1);
    applyStimulus("Y3",   0, 9'h000, 0, 0, 0, 0,  1, 9'h077, 1, 1, -1);
    applyStimulus("Y4",   0, 9'h000, 1, 0, 0, 0,  1, 9'h077, 1, 1, -1);
    applyStimulus("Y5",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // flush_young with a same-cycle output handshake leaves the pipe empty
    applyStimulus("H0",   1, 9'h0AA, 0, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("H1",   1, 9'h0BB, 0, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("H2",   0, 9'h000, 1, 0, 1, 0,  1, 9'h0AA, 0, 2,  0);
    applyStimulus("H3",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // Both flushes: flush_all wins and the tail entry is killed too
    applyStimulus("P0",   1, 9'h0CC, 0, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("P1",   0, 9'h000, 0, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("P2",   0, 9'h000, 0, 1, 1, 0,  1, 9'h0CC, 0, 1,  0);
    applyStimulus("P3",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // Reset mid-transfer aborts in-flight entries
    applyStimulus("R0",   1, 9'h0DD, 0, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("R1",   1, 9'h0EE, 0, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("R2",   0, 9'h000, 1, 0, 0, 1,  0, 9'h000, 0, 2,  0);
    applyStimulus("R3",   1, 9'h0F0, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("R4",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("R5",   0, 9'h000, 1, 0, 0, 0,  1, 9'h0F0, 1, 1, -1);
    applyStimulus("R6",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // Bubble: payload returns to zero after the handshake
    applyStimulus("U0",   1, 9'h1FF, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);
    applyStimulus("U1",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 1, -1);
    applyStimulus("U2",   0, 9'h000, 1, 0, 0, 0,  1, 9'h1FF, 1, 1, -1);
    applyStimulus("U3",   0, 9'h000, 1, 0, 0, 0,  0, 9'h000, 1, 0, -1);

    // DEPTH=3: fill 0x0C,0x0B,0x0A then flush_young leaves only 0x0C
    //             tag   iv  data    or fy  ov  odata   ir occ
    applyStimulus3("T0",  1, 9'h00C, 0, 0,  0, 9'h000, 1, 0);
    applyStimulus3("T1",  1, 9'h00B, 0, 0,  0, 9'h000, 1, 1);
    applyStimulus3("T2",  1, 9'h00A, 0, 0,  0, 9'h000, 1, 2);
    applyStimulus3("T3",  0, 9'h000, 0, 1,  1, 9'h00C, 0, 3);
    applyStimulus3("T4",  0, 9'h000, 0, 0,  1, 9'h00C, 1, 1);
    applyStimulus3("T5",  0, 9'h000, 1, 0,  1, 9'h00C, 1, 1);
    applyStimulus3("T6",  0, 9'h000, 1, 0,  0, 9'h000, 1, 0);

    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
